// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one memory data port between fetch (p0) and load/store (p1)
//  p0_*/p1_*  : requester side (read/write level requests, ready/valid pulses, load data)
//  mem_*      : downstream side (read/write pulses, held address/data, ready/valid/data in)
//  busy       : high while a transaction is in flight
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    p0_read,
  input  logic                    p0_write,
  input  logic [ADDRESS_BITS-1:0] p0_address,
  input  logic [DATA_WIDTH-1:0]   p0_store_data,
  output logic                    p0_ready,
  output logic                    p0_valid,
  output logic [DATA_WIDTH-1:0]   p0_load_data,
  input  logic                    p1_read,
  input  logic                    p1_write,
  input  logic [ADDRESS_BITS-1:0] p1_address,
  input  logic [DATA_WIDTH-1:0]   p1_store_data,
  output logic                    p1_ready,
  output logic                    p1_valid,
  output logic [DATA_WIDTH-1:0]   p1_load_data,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]   mem_in_data,
  input  logic                    mem_ready,
  input  logic                    mem_valid,
  input  logic [DATA_WIDTH-1:0]   mem_out_data,
  output logic                    busy
);
  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;
  state_t state, state_n;
  logic last_grant, is_write, req0, req1, win1, grant, wr, done;
  always_comb begin
    req0 = p0_read | p0_write;
    req1 = p1_read | p1_write;
    win1 = req1 & (~req0 | ~last_grant);
    grant = (state == IDLE) & mem_ready & (req0 | req1);
    wr = win1 ? p1_write : p0_write;
    done = (state != IDLE) & mem_valid;
    state_n = grant ? (win1 ? BUSY1 : BUSY0) : done ? IDLE : state;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= 1'b1;
      is_write <= 1'b0;
      p0_ready <= 1'b0;
      p1_ready <= 1'b0;
      p0_valid <= 1'b0;
      p1_valid <= 1'b0;
      p0_load_data <= '0;
      p1_load_data <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_address <= '0;
      mem_in_data <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      busy <= state_n != IDLE;
      mem_read <= grant & ~wr;
      mem_write <= grant & wr;
      p0_ready <= grant & ~win1;
      p1_ready <= grant & win1;
      p0_valid <= done & (state == BUSY0);
      p1_valid <= done & (state == BUSY1);
      if (grant) begin
        is_write <= wr;
        mem_address <= win1 ? p1_address : p0_address;
        mem_in_data <= win1 ? p1_store_data : p0_store_data;
      end
      // round-robin pointer only moves when both ports contend
      if (grant & req0 & req1) last_grant <= win1;
      if (done & ~is_write & (state == BUSY0)) p0_load_data <= mem_out_data;
      if (done & ~is_write & (state == BUSY1)) p1_load_data <= mem_out_data;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter
module tb_mem_port_arbiter;
  logic clock = 1'b0, reset = 1'b1;
  logic p0_read = 0, p0_write = 0, p1_read = 0, p1_write = 0;
  logic [19:0] p0_address = '0, p1_address = '0, mem_address;
  logic [31:0] p0_store_data = '0, p1_store_data = '0, mem_out_data = '0;
  logic [31:0] p0_load_data, p1_load_data, mem_in_data;
  logic p0_ready, p0_valid, p1_ready, p1_valid, mem_read, mem_write, busy;
  logic mem_ready = 1'b1, mem_valid = 1'b0;
  int checks = 0, failures = 0;
  mem_port_arbiter dut (
    .clock(clock), .reset(reset),
    .p0_read(p0_read), .p0_write(p0_write), .p0_address(p0_address), .p0_store_data(p0_store_data),
    .p0_ready(p0_ready), .p0_valid(p0_valid), .p0_load_data(p0_load_data),
    .p1_read(p1_read), .p1_write(p1_write), .p1_address(p1_address), .p1_store_data(p1_store_data),
    .p1_ready(p1_ready), .p1_valid(p1_valid), .p1_load_data(p1_load_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address), .mem_in_data(mem_in_data),
    .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_out_data(mem_out_data), .busy(busy)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clock);
  endtask
  task automatic wait_issue(input string tag);
    int n = 0;
    tick;
    while (!(mem_read | mem_write) && n < 20) begin
      tick;
      n++;
    end
    check({tag, "_issue"}, 32'(mem_read | mem_write), 1);
  endtask
  task automatic all_zero(input string tag);
    check({tag, "_ctl"}, {p0_ready, p0_valid, p1_ready, p1_valid, mem_read, mem_write, busy}, 0);
    check({tag, "_addr"}, 32'(mem_address), 0);
    check({tag, "_wdata"}, mem_in_data, 0);
    check({tag, "_ld0"}, p0_load_data, 0);
    check({tag, "_ld1"}, p1_load_data, 0);
  endtask
  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    tick;
  endtask
  initial begin
    tick;
    all_zero("reset");
    reset = 1'b0;
    tick;
    // single read from port 0
    p0_read = 1;
    p0_address = 20'h00010;
    tick;
    check("t1_mem_read", 32'(mem_read), 1);
    check("t1_ready", 32'(p0_ready), 1);
    check("t1_addr", 32'(mem_address), 32'h10);
    check("t1_busy", 32'(busy), 1);
    p0_read = 0;
    tick;
    check("t1_pulse", 32'({mem_read, p0_ready}), 0);
    tick;
    mem_valid = 1;
    mem_out_data = 32'hDEADBEEF;
    tick;
    mem_valid = 0;
    check("t1_valid", 32'(p0_valid), 1);
    check("t1_ld", p0_load_data, 32'hDEADBEEF);
    check("t1_idle", 32'(busy), 0);
    tick;
    check("t1_valid_off", 32'(p0_valid), 0);
    // contention: grants alternate starting with port 0
    do_reset();
    p0_read = 1;
    p1_read = 1;
    p0_address = 20'h00100;
    p1_address = 20'h00200;
    for (int k = 0; k < 4; k++) begin
      wait_issue("t2");
      check("t2_r0", 32'(p0_ready), 32'(k % 2 == 0));
      check("t2_r1", 32'(p1_ready), 32'(k % 2 == 1));
      check("t2_addr", 32'(mem_address), (k % 2 == 0) ? 32'h100 : 32'h200);
      tick;
      check("t2_overlap", 32'(mem_read), 0);
      mem_valid = 1;
      mem_out_data = 32'hA0 + 32'(k);
      tick;
      mem_valid = 0;
      check("t2_v0", 32'(p0_valid), 32'(k % 2 == 0));
      check("t2_v1", 32'(p1_valid), 32'(k % 2 == 1));
      if (k == 3) begin
        p0_read = 0;
        p1_read = 0;
      end
    end
    check("t2_ld0", p0_load_data, 32'hA2);
    check("t2_ld1", p1_load_data, 32'hA3);
    tick;
    check("t2_drain", 32'({mem_read, busy}), 0);
    // write from port 1
    p1_write = 1;
    p1_address = 20'h00020;
    p1_store_data = 32'h12345678;
    tick;
    p1_write = 0;
    check("t3_wr", 32'({mem_write, mem_read, p1_ready}), 32'b101);
    check("t3_addr", 32'(mem_address), 32'h20);
    check("t3_data", mem_in_data, 32'h12345678);
    mem_valid = 1;
    mem_out_data = 32'h0BAD0BAD;
    tick;
    mem_valid = 0;
    check("t3_valid", 32'(p1_valid), 1);
    check("t3_ld", p1_load_data, 32'hA3);
    tick;
    // backpressure
    mem_ready = 0;
    p0_read = 1;
    p0_address = 20'h00040;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("t4_stall", 32'({mem_read, p0_ready, busy}), 0);
    end
    mem_ready = 1;
    tick;
    p0_read = 0;
    check("t4_go", 32'({mem_read, p0_ready}), 32'b11);
    check("t4_addr", 32'(mem_address), 32'h40);
    // reset while BUSY0
    tick;
    check("t5_busy", 32'(busy), 1);
    #1 reset = 1;
    #1 all_zero("t5_async");
    tick;
    reset = 0;
    mem_valid = 1;
    mem_out_data = 32'hCAFEF00D;
    tick;
    mem_valid = 0;
    check("t5_novalid", 32'({p0_valid, p1_valid, busy}), 0);
    check("t5_ld", p0_load_data, 0);
    // read+write on one port counts as write
    p0_read = 1;
    p0_write = 1;
    p0_address = 20'h00030;
    p0_store_data = 32'h55AA55AA;
    wait_issue("t6");
    p0_read = 0;
    p0_write = 0;
    check("t6_rw", 32'({mem_write, mem_read}), 32'b10);
    check("t6_addr", 32'(mem_address), 32'h30);
    check("t6_data", mem_in_data, 32'h55AA55AA);
    mem_valid = 1;
    tick;
    mem_valid = 0;
    check("t6_valid", 32'(p0_valid), 1);
    check("t6_ld", p0_load_data, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
